// File: rtl/frame_timer_ctrl.sv
// -----------------------------------------------------------------------------
// frame_timer_ctrl
//
// Bit-timing sequencer for the receive/transmit datapath. A one-cycle start
// request launches a frame of bits_per_frame bit periods, each clks_per_bit
// clocks long. A phase counter tracks the position inside the current bit and
// a bit counter tracks completed bits. A three-state FSM (IDLE/RUN/DONE)
// sequences them. Every output is decoded from registered state only, so
// there is no combinational path from any input to any output.
//
// Parameters
//   CLK_BITS        width of the phase counter and of clks_per_bit
//   BIT_BITS        width of the bit counter, bits_per_frame and bit_index
//
// Ports
//   clk             system clock, rising edge
//   n_rst           asynchronous active-low reset
//   start           frame request, sampled only in IDLE
//   abort           cancel the running frame, effective only in RUN
//   clks_per_bit    clocks per bit period (legal 2 .. 2^CLK_BITS-1)
//   bits_per_frame  bits per frame (legal 1 .. 2^BIT_BITS-1)
//   busy            high in RUN and DONE
//   sample_strobe   one-cycle pulse at mid-bit (phase == clks_per_bit/2)
//   bit_end         one-cycle pulse on the last clock of each bit period
//   frame_done      one-cycle pulse in the cycle after a frame completes
//   cfg_err         one-cycle pulse after a start with an illegal config
//   bit_index       completed-bit count (0 in IDLE, bpf in DONE)
// -----------------------------------------------------------------------------
module frame_timer_ctrl #(
  parameter int CLK_BITS = 8,
  parameter int BIT_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CLK_BITS-1:0] clks_per_bit,
  input  logic [BIT_BITS-1:0] bits_per_frame,
  output logic                busy,
  output logic                sample_strobe,
  output logic                bit_end,
  output logic                frame_done,
  output logic                cfg_err,
  output logic [BIT_BITS-1:0] bit_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;

  // Configuration latched on a start request in IDLE.
  logic [CLK_BITS-1:0] cpb;
  logic [BIT_BITS-1:0] bpf;
  logic [CLK_BITS-1:0] half;

  logic                cfg_err_q;

  logic [CLK_BITS-1:0] phase;
  logic                phase_at_end;
  logic [BIT_BITS-1:0] bit_cnt;
  logic                bit_cnt_full;

  logic                start_req;
  logic                last_bit;

  logic                phase_clear;
  logic                phase_en;
  logic                bit_clear;
  logic                bit_en;

  // A frame needs at least two clocks per bit (so mid-bit is distinct from
  // the bit boundary) and at least one bit.
  function automatic logic cfg_legal(input logic [CLK_BITS-1:0] c,
                                     input logic [BIT_BITS-1:0] b);
    return (c >= CLK_BITS'(2)) && (b != '0);
  endfunction

  assign start_req = (state == IDLE) && start;
  assign half      = cpb >> 1;
  assign last_bit  = (bit_cnt == (bpf - BIT_BITS'(1)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration latch and configuration-error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cpb       <= '0;
      bpf       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_req && !cfg_legal(clks_per_bit, bits_per_frame);
      if (start_req) begin
        cpb <= clks_per_bit;
        bpf <= bits_per_frame;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Abort outranks the final bit_end so an aborted frame
  // never reports frame_done.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start && cfg_legal(clks_per_bit, bits_per_frame)) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
        end else if (bit_end && last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter controls. The phase counter is steered by next_state so it
  // already reads 1 in the first RUN cycle and drops to 0 as soon as RUN is
  // left. The bit counter keeps its value into DONE (where it equals bpf)
  // and is cleared on any return to IDLE.
  // ---------------------------------------------------------------------------
  assign phase_clear = (next_state != RUN);
  assign phase_en    = (next_state == RUN);
  assign bit_clear   = (next_state == IDLE);
  assign bit_en      = bit_end;

  flex_counter #(
    .NUM_CNT_BITS (CLK_BITS)
  ) u_phase_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (phase_clear),
    .count_enable  (phase_en),
    .rollover_val  (cpb),
    .count_out     (phase),
    .rollover_flag (phase_at_end)
  );

  flex_counter #(
    .NUM_CNT_BITS (BIT_BITS)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (bit_clear),
    .count_enable  (bit_en),
    .rollover_val  (bpf),
    .count_out     (bit_cnt),
    .rollover_flag (bit_cnt_full)
  );

  // ---------------------------------------------------------------------------
  // Moore output decode
  // ---------------------------------------------------------------------------
  assign busy          = (state != IDLE);
  assign sample_strobe = (state == RUN) && (phase == half);
  assign bit_end       = (state == RUN) && phase_at_end;
  // In DONE the bit counter has just reached bpf; requiring that as well
  // keeps frame_done tied to a genuinely completed bit count.
  assign frame_done    = (state == DONE) && bit_cnt_full;
  assign cfg_err       = cfg_err_q;
  assign bit_index     = bit_cnt;

endmodule

// -----------------------------------------------------------------------------
// flex_counter
//
// Up-counter with synchronous clear that counts 1..rollover_val and wraps
// back to 1. rollover_flag is a decode of the registered count, high while
// the count equals rollover_val.
//
// Ports
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset (count -> 0)
//   clear          synchronous clear to 0, priority over count_enable
//   count_enable   advance the count this cycle
//   rollover_val   terminal count; the next advance wraps to 1
//   count_out      current count
//   rollover_flag  count_out == rollover_val
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_out <= NUM_CNT_BITS'(1);
      end else begin
        count_out <= count_out + NUM_CNT_BITS'(1);
      end
    end
  end

  assign rollover_flag = (count_out == rollover_val);

endmodule

// File: tb/tb_frame_timer_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for frame_timer_ctrl. A driver issues one cycle of stimulus at a
// time and pushes the reference model's prediction for the following cycle
// into a queue; an independent monitor pops one prediction per clock and
// compares it with what the DUT presents. The reference model computes each
// cycle's outputs directly from the frame timing formulas.
// -----------------------------------------------------------------------------
module tb_frame_timer_ctrl;

  localparam int CB = 8;
  localparam int BB = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CB-1:0] clks_per_bit = '0;
  logic [BB-1:0] bits_per_frame = '0;
  logic          busy;
  logic          sample_strobe;
  logic          bit_end;
  logic          frame_done;
  logic          cfg_err;
  logic [BB-1:0] bit_index;

  frame_timer_ctrl #(
    .CLK_BITS (CB),
    .BIT_BITS (BB)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .abort          (abort),
    .clks_per_bit   (clks_per_bit),
    .bits_per_frame (bits_per_frame),
    .busy           (busy),
    .sample_strobe  (sample_strobe),
    .bit_end        (bit_end),
    .frame_done     (frame_done),
    .cfg_err        (cfg_err),
    .bit_index      (bit_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          smp;
    logic          bend;
    logic          done;
    logic          err;
    logic          busy;
    logic [BB-1:0] idx;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    cyc_q[$];

  int errors = 0;
  int checks = 0;

  function automatic obs_t observe();
    obs_t o;
    o.smp  = sample_strobe;
    o.bend = bit_end;
    o.done = frame_done;
    o.err  = cfg_err;
    o.busy = busy;
    o.idx  = bit_index;
    return o;
  endfunction

  // Reference: outputs in cycle c (cycle 1 follows the edge that samples the
  // start request) for a frame started with (cpb, bpf), with abort sampled at
  // edge ab (ignored unless the block is running then, i.e. 1 <= ab <= cpb*bpf).
  function automatic obs_t model(int c, int cpb, int bpf, int ab);
    obs_t e;
    int   n;
    int   p;
    e = '0;
    n = cpb * bpf;
    if (cpb < 2 || bpf < 1) begin
      e.err = (c == 1);
      return e;
    end
    if (ab >= 1 && ab <= n && c > ab) return e;
    if (c <= n) begin
      p      = (c - 1) % cpb + 1;
      e.busy = 1'b1;
      e.smp  = (p == cpb / 2);
      e.bend = (p == cpb);
      e.idx  = BB'((c - 1) / cpb);
    end else if (c == n + 1) begin
      e.busy = 1'b1;
      e.done = 1'b1;
      e.idx  = BB'(bpf);
    end
    return e;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("smp=%0b end=%0b done=%0b err=%0b busy=%0b idx=%0d",
                     o.smp, o.bend, o.done, o.err, o.busy, o.idx);
  endfunction

  // Monitor: one prediction consumed per clock, sampled after the edge.
  initial begin
    obs_t  e;
    obs_t  a;
    string t;
    int    c;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        c = cyc_q.pop_front();
        a = observe();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s cyc%0d: got %s, want %s", t, c, fmt(a), fmt(e));
        end
      end
    end
  end

  task automatic check_now(input string t, input obs_t e);
    obs_t a;
    a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %s, want %s", t, fmt(a), fmt(e));
    end
  endtask

  // Drive inputs for the next active edge and predict the cycle it begins.
  task automatic step(input logic s, input logic ab, input logic [CB-1:0] c,
                      input logic [BB-1:0] b, input obs_t e, input string t,
                      input int rel);
    @(negedge clk);
    start          = s;
    abort          = ab;
    clks_per_bit   = c;
    bits_per_frame = b;
    exp_q.push_back(e);
    tag_q.push_back(t);
    cyc_q.push_back(rel);
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, '0, '0, '0, "idle", i + 1);
  endtask

  // One frame request. mode 0: quiet inputs; mode 1: random start pulses
  // while busy, random abort while idle, random config noise after edge 0;
  // mode 2: start at edges 3 and 13, clks_per_bit forced to 9 from edge 2.
  task automatic run_scn(input string t, input int cpb, input int bpf,
                         input int ab, input int mode, input int pad);
    int            n;
    int            base;
    int            th;
    int            last_busy;
    bit            legal;
    bit            aborted;
    logic          s;
    logic          a;
    logic [CB-1:0] c;
    logic [BB-1:0] b;
    legal     = (cpb >= 2) && (bpf >= 1);
    n         = cpb * bpf;
    aborted   = legal && ab >= 1 && ab <= n;
    last_busy = !legal ? 0 : (aborted ? ab : n + 1);
    th        = !legal ? 0 : (aborted ? ab : n);
    base      = !legal ? 1 : (aborted ? ab + 1 : n + 2);
    for (int i = 0; i < base + pad; i++) begin
      s = (i == 0);
      a = (ab >= 0) && (i == ab);
      c = CB'(cpb);
      b = BB'(bpf);
      if (mode == 1 && i > 0) begin
        if (i <= last_busy) s = ($urandom_range(0, 3) == 0);
        if (i > th) a = ($urandom_range(0, 3) == 0);
        c = CB'($urandom);
        b = BB'($urandom);
      end
      if (mode == 2) begin
        if (i == 3 || i == 13) s = 1'b1;
        if (i >= 2) c = CB'(9);
      end
      step(s, a, c, b, model(i + 1, cpb, bpf, ab), t, i + 1);
    end
  endtask

  task automatic reset_mid_frame();
    for (int i = 0; i < 6; i++)
      step(i == 0, 1'b0, CB'(4), BB'(3), model(i + 1, 4, 3, -1), "rst_pre", i + 1);
    @(posedge clk);
    #4;
    n_rst = 1'b0;
    #1;
    check_now("rst_async_drop", '0);
    @(posedge clk);
    #2;
    check_now("rst_held", '0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpb;
    int bpf;
    int ab;
    #12;
    check_now("reset_state", '0);
    @(negedge clk);
    n_rst = 1'b1;
    idle_steps(3);

    run_scn("nominal",       4, 3, -1, 0, 0);
    run_scn("odd_cpb5",      5, 2, -1, 0, 1);
    run_scn("min_cpb2",      2, 1, -1, 0, 1);
    run_scn("bad_cpb1",      1, 3, -1, 0, 2);
    run_scn("bad_bpf0",      4, 0, -1, 0, 2);
    run_scn("bad_cpb0",      0, 5, -1, 0, 1);
    run_scn("abort_final",   4, 3, 12, 0, 1);
    run_scn("after_abort",   4, 3, -1, 0, 0);
    run_scn("ignored_in",    4, 3, -1, 2, 0);
    run_scn("start_at_14",   4, 3, -1, 0, 0);
    run_scn("abort_in_done", 3, 2, 7, 0, 1);
    run_scn("abort_mid",     6, 4, 9, 0, 0);
    run_scn("max_cpb",     255, 2, -1, 0, 1);
    run_scn("max_bpf",       3, 15, -1, 0, 1);

    reset_mid_frame();
    run_scn("post_reset",    4, 3, -1, 0, 1);

    for (int r = 0; r < 30; r++) begin
      cpb = $urandom_range(2, 10);
      bpf = $urandom_range(1, 15);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) cpb = $urandom_range(0, 1);
        else bpf = 0;
      end
      ab = -1;
      if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, cpb * bpf + 1);
      run_scn($sformatf("rand%0d", r), cpb, bpf, ab, 1, $urandom_range(0, 3));
    end

    idle_steps(2);
    @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_timer_ctrl.md
# frame_timer_ctrl

Sequencing controller for the receive/transmit bit-timing datapath. It accepts a one-cycle start request and runs a frame of `bits_per_frame` bit periods, each `clks_per_bit` clocks long. It is built from two `flex_counter` instances, a phase counter and a bit counter, driven by a small FSM. It emits a mid-bit sample strobe, an end-of-bit strobe, and a frame-done pulse for the shift register and packet logic.

## Interface
- `CLK_BITS`, default 8: width of the phase counter and of `clks_per_bit`.
- `BIT_BITS`, default 4: width of the bit counter, `bits_per_frame` and `bit_index`.

- `clk` input 1: system clock, rising edge.
- `n_rst` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` input 1: frame request. Sampled only in IDLE.
- `abort` input 1: cancel the current frame. Effective in RUN only.
- `clks_per_bit` input `CLK_BITS`: clocks per bit period. Legal range is 2 to 2^CLK_BITS−1.
- `bits_per_frame` input `BIT_BITS`: bits per frame. Legal range is 1 to 2^BIT_BITS−1.
- `busy` output 1: high in RUN and DONE.
- `sample_strobe` output 1: one-cycle pulse at mid-bit.
- `bit_end` output 1: one-cycle pulse on the last clock of each bit period.
- `frame_done` output 1: one-cycle pulse after a frame completes normally.
- `cfg_err` output 1: one-cycle pulse when `start` is sampled with an illegal configuration.
- `bit_index` output `BIT_BITS`: count of bits already completed in the frame.

## Operation
- **States:** IDLE, RUN and DONE. The reset state is IDLE.
- **Reset values:** on reset, all outputs are 0, both counters are cleared and the latched configuration is 0.
- **Start in IDLE:** when `start`=1 in IDLE, `clks_per_bit` and `bits_per_frame` are latched into cpb and bpf on that edge.
  - If cpb<2 or bpf==0, the block stays in IDLE and `cfg_err`=1 for the next cycle.
  - Otherwise the block moves to RUN.
- **Inputs during a frame:** `start` is ignored in RUN and DONE. Configuration inputs are ignored except on an accepted start.
- **RUN, phase counter:**
  - The phase counter p increments on every RUN cycle, running 1..cpb and wrapping back to 1.
  - p=1 on the first RUN cycle. p is held cleared outside RUN.
  - half = cpb>>1, an unsigned logical shift, so half≥1.
- **RUN, strobes and bit counter:**
  - `sample_strobe` = RUN && p==half.
  - `bit_end` = RUN && p==cpb.
  - The bit counter increments on each `bit_end`.
- **RUN to DONE:** `bit_end` with bit_index==bpf−1 moves the block to DONE.
- **`bit_index` value by state:** bit_index is 0 in IDLE, equals the completed-bit count in RUN, and equals bpf in DONE.
- **DONE:** lasts exactly one cycle, with `frame_done`=1 and `busy`=1, then the block returns to IDLE. On the return to IDLE both counters are cleared.
- **Abort:**
  - `abort`=1 in RUN moves the block to IDLE on the next edge and clears both counters.
  - `frame_done` is not pulsed and `bit_end` bookkeeping is discarded.
  - Abort has priority over a simultaneous final `bit_end`.
  - `abort` in IDLE or DONE is ignored.
- **Mid-frame reset:** asserting `n_rst` mid-frame returns the block to IDLE with all outputs at 0 immediately, without waiting for a clock edge.
- **Output timing:** all outputs are Moore decodes of registered state and counters. There is no combinational path from any input to any output.

## Timing
- Let cycle 0 be the edge where `start` is accepted.
- RUN occupies cycles 1..cpb·bpf.
- For bit k (0-based), `sample_strobe` fires at cycle k·cpb+half and `bit_end` fires at cycle (k+1)·cpb.
- DONE and `frame_done` occur at cycle cpb·bpf+1.
- IDLE is re-entered at cycle cpb·bpf+2. That cycle is the earliest at which a new `start` is accepted.
- `busy` is high during cycles 1..cpb·bpf+1.
- `cfg_err` fires at cycle 1 when the configuration is illegal.
- Abort sampled at cycle n: the block is in IDLE at cycle n+1, with `busy`=0 and `bit_index`=0.
- Latency from `start` to the first `sample_strobe` is half cycles.

## Test plan
- **Nominal frame:** cpb=4, bpf=3, start at cycle 0.
  - `sample_strobe` at cycles 2, 6 and 10.
  - `bit_end` at cycles 4, 8 and 12.
  - `bit_index` is 1 at cycle 5, 2 at cycle 9, and 3 at cycle 13.
  - `frame_done` at cycle 13; `busy` is high during cycles 1..13.
- **Odd and minimum periods:**
  - cpb=5, bpf=2: samples at cycles 2 and 7, `bit_end` at cycles 5 and 10, `frame_done` at cycle 11.
  - cpb=2, bpf=1: sample at cycle 1, `bit_end` at cycle 2, `frame_done` at cycle 3.
- **Illegal configuration:**
  - cpb=1 with bpf=3: `cfg_err`=1 at cycle 1 only, `busy` never asserts.
  - Repeat with cpb=4, bpf=0: same response.
- **Abort:** cpb=4, bpf=3, `abort` at cycle 12 (coincident with the final `bit_end`).
  - IDLE at cycle 13, no `frame_done`, `bit_index`=0.
  - A new start at cycle 14 runs a clean frame.
- **Ignored inputs:** `start` pulsed at cycles 3 and 13, and `clks_per_bit` changed to 9 at cycle 2, during a cpb=4, bpf=3 frame.
  - The timing matches the nominal frame exactly.
  - A start at cycle 14 (IDLE) is accepted.
- **Reset mid-frame:** `n_rst` driven low asynchronously at mid-cycle 6.
  - All outputs drop to 0 immediately.
  - After release, the first start is accepted and timed as in the nominal frame.
